// File: rtl/rx_atten_ctrl_pkg.sv
// Shared types and constants for the receiver attenuation/filter sequencer.
package rx_atten_ctrl_pkg;

  localparam int unsigned DEF_TAPS   = 32;
  localparam int unsigned DEF_CODE_W = 5;

  localparam int unsigned ATTEN_2  = 2;
  localparam int unsigned ATTEN_4  = 4;
  localparam int unsigned ATTEN_8  = 8;
  localparam int unsigned ATTEN_16 = 16;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    SETTLE,
    LOCKED
  } rx_ctrl_state_t;

  // Code is passed zero-extended so wide codes cannot alias onto a legal value.
  function automatic logic is_legal_atten(input logic [31:0] code);
    return (code == ATTEN_2) || (code == ATTEN_4) ||
           (code == ATTEN_8) || (code == ATTEN_16);
  endfunction

endpackage

// File: rtl/rx_atten_ctrl_counter.sv
// Saturating up-counter with clear and enable; term flags the saturation value.
module rx_settle_counter #(
  parameter int unsigned MAX = 32,
  parameter int unsigned W   = $clog2(MAX + 2)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == W'(MAX));

endmodule

// File: rtl/rx_atten_ctrl.sv
// Attenuation-code sequencer: validates requests, flushes the filter, and
// counts sample strobes until the moving-average window is all post-change.
module rx_atten_ctrl
  import rx_atten_ctrl_pkg::*;
#(
  parameter int unsigned TAPS         = DEF_TAPS,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CODE_W       = DEF_CODE_W
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        SAMPLE_EN,
  input  logic                        REQ_VALID,
  input  logic [CODE_W-1:0]           REQ_CODE,
  output logic                        REQ_READY,
  output logic [CODE_W-1:0]           ATTEN_CFG,
  output logic                        FILT_RESET,
  output logic                        SETTLING,
  output logic                        OUT_VALID,
  output logic                        ERR_BADCODE,
  output logic [$clog2(TAPS+1)-1:0]   SETTLE_CNT
);

  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

  rx_ctrl_state_t state_q, state_d;
  logic [CODE_W-1:0] atten_q, atten_d;
  logic filt_q, filt_d;
  logic settling_q, settling_d;
  logic out_valid_q, out_valid_d;
  logic err_q, err_d;
  logic ready_q, ready_d;

  logic accept;
  logic legal;
  logic restart;
  logic flush_term;
  logic settle_term;
  logic [FL_W-1:0] flush_cnt;
  logic [CNT_W-1:0] settle_cnt;
  logic unused_flush;

  assign accept = REQ_VALID && ready_q;
  assign legal  = is_legal_atten(32'(REQ_CODE));
  // Re-requesting the locked code is a no-op; in SETTLE it restarts the flush.
  assign restart = accept && legal &&
                   !((state_q == LOCKED) && (REQ_CODE == atten_q));

  // Flush counter saturates at FLUSH_CYCLES-1, i.e. on the last flush cycle.
  rx_settle_counter #(
    .MAX (FLUSH_CYCLES - 1),
    .W   (FL_W)
  ) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (restart),
    .en    (state_q == FLUSH),
    .cnt   (flush_cnt),
    .term  (flush_term)
  );

  rx_settle_counter #(
    .MAX (TAPS),
    .W   (CNT_W)
  ) u_settle_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (restart),
    .en    ((state_q == SETTLE) && SAMPLE_EN && !accept),
    .cnt   (settle_cnt),
    .term  (settle_term)
  );

  assign unused_flush = ^flush_cnt;

  always_comb begin
    state_d = state_q;
    atten_d = atten_q;
    if (restart) begin
      state_d = FLUSH;
      atten_d = REQ_CODE;
    end else begin
      case (state_q)
        FLUSH:   if (flush_term)  state_d = SETTLE;
        SETTLE:  if (settle_term) state_d = LOCKED;
        default: ;
      endcase
    end
    // Outputs are registered from the next state so they align with it.
    filt_d      = (state_d == FLUSH);
    settling_d  = (state_d == FLUSH) || (state_d == SETTLE);
    out_valid_d = (state_d == LOCKED);
    ready_d     = (state_d != FLUSH);
    err_d       = accept && !legal;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      atten_q     <= '0;
      filt_q      <= 1'b0;
      settling_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      atten_q     <= atten_d;
      filt_q      <= filt_d;
      settling_q  <= settling_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign REQ_READY   = ready_q;
  assign ATTEN_CFG   = atten_q;
  assign FILT_RESET  = filt_q;
  assign SETTLING    = settling_q;
  assign OUT_VALID   = out_valid_q;
  assign ERR_BADCODE = err_q;
  assign SETTLE_CNT  = settle_cnt;

endmodule

// File: tb/tb_rx_atten_ctrl.sv
// Scenario bench for rx_atten_ctrl: expected lock events are queued at request
// time and checked by a monitor when OUT_VALID rises.
module tb_rx_atten_ctrl;

  localparam int TAPS   = 32;
  localparam int FLUSH  = 2;
  localparam int CODE_W = 5;
  localparam int CW     = $clog2(TAPS + 1);

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SAMPLE_EN = 1'b0;
  logic REQ_VALID = 1'b0;
  logic [CODE_W-1:0] REQ_CODE = '0;
  logic REQ_READY;
  logic [CODE_W-1:0] ATTEN_CFG;
  logic FILT_RESET;
  logic SETTLING;
  logic OUT_VALID;
  logic ERR_BADCODE;
  logic [CW-1:0] SETTLE_CNT;

  rx_atten_ctrl #(
    .TAPS         (TAPS),
    .FLUSH_CYCLES (FLUSH),
    .CODE_W       (CODE_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SAMPLE_EN   (SAMPLE_EN),
    .REQ_VALID   (REQ_VALID),
    .REQ_CODE    (REQ_CODE),
    .REQ_READY   (REQ_READY),
    .ATTEN_CFG   (ATTEN_CFG),
    .FILT_RESET  (FILT_RESET),
    .SETTLING    (SETTLING),
    .OUT_VALID   (OUT_VALID),
    .ERR_BADCODE (ERR_BADCODE),
    .SETTLE_CNT  (SETTLE_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int period = 1;

  typedef struct {
    logic [CODE_W-1:0] code;
    int                rise;
  } exp_t;
  exp_t sb[$];

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    SAMPLE_EN = (period != 0) && ((cyc % period) == 0);
  endtask

  // Cycle at which OUT_VALID must rise for a request accepted at cycle ta.
  function automatic int exp_rise(input int ta);
    int n = 0;
    for (int c = ta + FLUSH + 1; c < ta + 100000; c++) begin
      if (period != 0 && (c % period) == 0) n++;
      if (n == TAPS) return c + 2;
    end
    return -1;
  endfunction

  logic prev_ov = 1'b0;
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET) begin
      prev_ov = OUT_VALID;
    end else begin
      if (FILT_RESET === 1'b1) begin
        tests++;
        if (REQ_READY !== 1'b0) begin
          fails++;
          $display("FAIL ready_in_flush: cycle %0d REQ_READY=%b required 0", cyc, REQ_READY);
        end
      end
      if (OUT_VALID === 1'b1 && prev_ov === 1'b0) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_lock: cycle %0d OUT_VALID rose, none expected", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.rise || ATTEN_CFG !== e.code || SETTLE_CNT !== CW'(TAPS)) begin
            fails++;
            $display("FAIL lock_event: cycle=%0d cfg=%0d cnt=%0d, required cycle=%0d cfg=%0d cnt=%0d",
                     cyc, ATTEN_CFG, SETTLE_CNT, e.rise, e.code, TAPS);
          end
        end
      end
      prev_ov = OUT_VALID;
    end
  end

  task automatic do_req(input logic [CODE_W-1:0] code, output int ta);
    REQ_VALID = 1'b1;
    REQ_CODE  = code;
    for (int i = 0; i < 50 && REQ_READY !== 1'b1; i++) step();
    tests++;
    if (REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL req_ready_timeout: REQ_READY=%b required 1 for code %0d", REQ_READY, code);
    end
    ta = cyc;
    step();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_lock(input int budget);
    for (int i = 0; i < budget && OUT_VALID !== 1'b1; i++) step();
    tests++;
    if (OUT_VALID !== 1'b1) begin
      fails++;
      $display("FAIL lock_timeout: OUT_VALID=%b required 1 within %0d cycles", OUT_VALID, budget);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) step();
    tests++;
    if ({REQ_READY, ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, ERR_BADCODE, SETTLE_CNT} !== '0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b cfg=%0d fr=%b st=%b ov=%b err=%b cnt=%0d required all 0",
               REQ_READY, ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, ERR_BADCODE, SETTLE_CNT);
    end
    RESET = 1'b0;
    repeat (2) step();
    tests++;
    if (REQ_READY !== 1'b1 || SETTLING !== 1'b0) begin
      fails++;
      $display("FAIL idle_ready: rdy=%b settling=%b required 1/0", REQ_READY, SETTLING);
    end
  endtask

  task automatic test_basic_lock();
    int ta;
    period = 1;
    do_req(5'd8, ta);
    sb.push_back('{5'd8, exp_rise(ta)});
    tests++;
    if ({ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, SETTLE_CNT} !== {5'd8, 1'b1, 1'b1, 1'b0, 6'd0}) begin
      fails++;
      $display("FAIL accept_8: cfg=%0d fr=%b st=%b ov=%b cnt=%0d required 8/1/1/0/0",
               ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, SETTLE_CNT);
    end
    step();
    tests++;
    if (FILT_RESET !== 1'b1) begin
      fails++;
      $display("FAIL flush_second_cycle: FILT_RESET=%b required 1", FILT_RESET);
    end
    step();
    tests++;
    if ({FILT_RESET, SETTLING, REQ_READY} !== 3'b011) begin
      fails++;
      $display("FAIL settle_entry: fr=%b st=%b rdy=%b required 0/1/1", FILT_RESET, SETTLING, REQ_READY);
    end
    wait_lock(60);
    tests++;
    if (SETTLE_CNT !== 6'd32 || SETTLING !== 1'b0 || ATTEN_CFG !== 5'd8) begin
      fails++;
      $display("FAIL locked_8: cnt=%0d st=%b cfg=%0d required 32/0/8", SETTLE_CNT, SETTLING, ATTEN_CFG);
    end
  endtask

  task automatic test_badcode();
    int ta;
    do_req(5'd13, ta);
    tests++;
    if ({ERR_BADCODE, ATTEN_CFG, OUT_VALID, SETTLE_CNT} !== {1'b1, 5'd8, 1'b1, 6'd32}) begin
      fails++;
      $display("FAIL badcode: err=%b cfg=%0d ov=%b cnt=%0d required 1/8/1/32",
               ERR_BADCODE, ATTEN_CFG, OUT_VALID, SETTLE_CNT);
    end
    step();
    tests++;
    if (ERR_BADCODE !== 1'b0 || OUT_VALID !== 1'b1) begin
      fails++;
      $display("FAIL badcode_pulse: err=%b ov=%b required 0/1", ERR_BADCODE, OUT_VALID);
    end
  endtask

  task automatic test_abort_settle();
    int ta;
    period = 1;
    do_req(5'd2, ta);
    sb.push_back('{5'd2, exp_rise(ta)});
    for (int i = 0; i < 60 && SETTLE_CNT !== 6'd10; i++) step();
    tests++;
    if (SETTLE_CNT !== 6'd10) begin
      fails++;
      $display("FAIL reach_cnt10: SETTLE_CNT=%0d required 10", SETTLE_CNT);
    end
    void'(sb.pop_back());
    do_req(5'd16, ta);
    sb.push_back('{5'd16, exp_rise(ta)});
    tests++;
    if ({ATTEN_CFG, OUT_VALID, SETTLE_CNT, FILT_RESET} !== {5'd16, 1'b0, 6'd0, 1'b1}) begin
      fails++;
      $display("FAIL abort_16: cfg=%0d ov=%b cnt=%0d fr=%b required 16/0/0/1",
               ATTEN_CFG, OUT_VALID, SETTLE_CNT, FILT_RESET);
    end
    wait_lock(60);
  endtask

  task automatic test_slow_strobe();
    int ta;
    period = 4;
    // Align so a strobe lands inside the flush window.
    for (int i = 0; i < 8 && ((cyc + 1) % 4) != 0; i++) step();
    do_req(5'd2, ta);
    sb.push_back('{5'd2, exp_rise(ta)});
    for (int i = 0; i < FLUSH; i++) begin
      tests++;
      if (REQ_READY !== 1'b0 || SETTLE_CNT !== 6'd0) begin
        fails++;
        $display("FAIL slow_flush: rdy=%b cnt=%0d required 0/0", REQ_READY, SETTLE_CNT);
      end
      step();
    end
    wait_lock(200);
  endtask

  task automatic test_noop_and_reset();
    int ta;
    period = 1;
    do_req(5'd4, ta);
    sb.push_back('{5'd4, exp_rise(ta)});
    wait_lock(60);
    do_req(5'd4, ta);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({FILT_RESET, OUT_VALID, SETTLING, SETTLE_CNT, ATTEN_CFG} !== {1'b0, 1'b1, 1'b0, 6'd32, 5'd4}) begin
        fails++;
        $display("FAIL noop_same_code: fr=%b ov=%b st=%b cnt=%0d cfg=%0d required 0/1/0/32/4",
                 FILT_RESET, OUT_VALID, SETTLING, SETTLE_CNT, ATTEN_CFG);
      end
      step();
    end
    do_req(5'd2, ta);
    tests++;
    if (FILT_RESET !== 1'b1) begin
      fails++;
      $display("FAIL midflush_entry: FILT_RESET=%b required 1", FILT_RESET);
    end
    RESET = 1'b1;
    step();
    tests++;
    if ({REQ_READY, ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, ERR_BADCODE, SETTLE_CNT} !== '0) begin
      fails++;
      $display("FAIL midflush_reset: rdy=%b cfg=%0d fr=%b st=%b ov=%b err=%b cnt=%0d required all 0",
               REQ_READY, ATTEN_CFG, FILT_RESET, SETTLING, OUT_VALID, ERR_BADCODE, SETTLE_CNT);
    end
    RESET = 1'b0;
    repeat (3) step();
    tests++;
    if (REQ_READY !== 1'b1 || FILT_RESET !== 1'b0 || ATTEN_CFG !== 5'd0) begin
      fails++;
      $display("FAIL post_reset_idle: rdy=%b fr=%b cfg=%0d required 1/0/0", REQ_READY, FILT_RESET, ATTEN_CFG);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_badcode();
    test_abort_settle();
    test_slow_strobe();
    test_noop_and_reset();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d lock events outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
